// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmit path among NREQ byte producers. Requesters are granted
//   round-robin, with up to BURST back-to-back bytes for an owner that keeps req high.
//   The granted byte is latched onto tx_data and tx_trans is raised until tx_done.
//   tx_trans is then held low for GAP_CYC cycles so the transmitter can return to IDLE.
//   The requester is acked on the same edge that tx_trans falls.
//
// Ports
//   clk, reset   system clock; synchronous active-high reset
//   req          per-requester byte valid, held until ack
//   req_data     requester i byte at [i*DATA_W +: DATA_W]
//   ack          one-cycle pulse when requester's byte has been transmitted
//   tx_trans     trans strobe to the transmitter
//   tx_data      latched byte to the transmitter shift register
//   tx_done      one-cycle pulse from the transmitter at end of stop bit
//   grant_id     current owner, valid while busy
//   busy         high from grant until the final gap cycle ends
//   timeout_err  sticky watchdog error
//
// Configuration
//   UART_TX_SCHED_TIMEOUT_EN  when defined, a SEND watchdog aborts a frame after TIMEOUT
//                             cycles without tx_done. When undefined, timeout_err is 0.
module uart_tx_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BURST   = 4,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic [NREQ-1:0]         ack,
    output logic                    tx_trans,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned ID_W    = $clog2(NREQ);
    localparam int unsigned BURST_W = $clog2(BURST + 1);
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [ID_W:0]      NREQ_V    = (ID_W + 1)'(NREQ);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST);
    localparam logic [GAP_W-1:0]   GAP_INIT  = GAP_W'(GAP_CYC - 1);

    if (NREQ < 2 || NREQ > 8 || BURST < 1 || BURST > 15 || GAP_CYC < 1 || TIMEOUT < 1)
    begin : g_param_check
        $error("uart_tx_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [BURST_W-1:0] burst_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W:0]      idx;
    logic [DATA_W-1:0]  pick_data;
    logic [DATA_W-1:0]  own_data;
    logic               burst_go;

    function automatic logic [DATA_W-1:0] byte_sel(input logic [NREQ*DATA_W-1:0] bus,
                                                   input logic [ID_W-1:0] id);
        logic [DATA_W-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (id == ID_W'(i)) b = bus[i*DATA_W +: DATA_W];
        end
        return b;
    endfunction

    // First requester found searching upward from rr_ptr+1, wrapping modulo NREQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = {1'b0, rr_ptr} + (ID_W + 1)'(off);
            if (idx >= NREQ_V) idx = idx - NREQ_V;
            if (!pick_valid && req[idx[ID_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = idx[ID_W-1:0];
            end
        end
    end

    assign pick_data = byte_sel(req_data, pick_id);
    assign own_data  = byte_sel(req_data, grant_id);
    assign burst_go  = req[grant_id] && (burst_cnt < BURST_MAX);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = ($clog2(TIMEOUT) > 13) ? $clog2(TIMEOUT) : 13;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            rr_ptr    <= ID_W'(NREQ - 1);
            burst_cnt <= '0;
            gap_cnt   <= '0;
            tx_trans  <= 1'b0;
            tx_data   <= '0;
            ack       <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            // Watchdog restarts on every entry to SEND.
            if (state != StSend) wd_cnt <= '0;
`endif
            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        grant_id  <= pick_id;
                        rr_ptr    <= pick_id;
                        tx_data   <= pick_data;
                        tx_trans  <= 1'b1;
                        busy      <= 1'b1;
                        burst_cnt <= BURST_W'(1);
                        state     <= StSend;
                    end
                end
                StSend: begin
                    if (tx_done) begin
                        tx_trans <= 1'b0;
                        ack      <= NREQ'(1) << grant_id;
                        gap_cnt  <= GAP_INIT;
                        state    <= StGap;
                    end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        // Abort without ack; saturating burst_cnt makes the stalled owner
                        // lose the burst continuation so others are served next.
                        tx_trans    <= 1'b0;
                        timeout_err <= 1'b1;
                        burst_cnt   <= BURST_MAX;
                        gap_cnt     <= GAP_INIT;
                        state       <= StGap;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                StGap: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (burst_go) begin
                        tx_data   <= own_data;
                        tx_trans  <= 1'b1;
                        burst_cnt <= burst_cnt + 1'b1;
                        state     <= StSend;
                    end else if (pick_valid) begin
                        // rr_ptr still holds the previous owner, so it has lowest priority.
                        grant_id  <= pick_id;
                        rr_ptr    <= pick_id;
                        tx_data   <= pick_data;
                        tx_trans  <= 1'b1;
                        burst_cnt <= BURST_W'(1);
                        state     <= StSend;
                    end else begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the scheduling rules.
module tb_uart_tx_scheduler;

    localparam int NREQ    = 4;
    localparam int DATA_W  = 8;
    localparam int BURST   = 4;
    localparam int GAP_CYC = 2;
    localparam int TIMEOUT = 4096;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic                   tx_done = 1'b0;
    logic [NREQ-1:0]        ack;
    logic                   tx_trans;
    logic [DATA_W-1:0]      tx_data;
    logic [1:0]             grant_id;
    logic                   busy;
    logic                   timeout_err;

    uart_tx_scheduler #(
        .NREQ    (NREQ),
        .DATA_W  (DATA_W),
        .BURST   (BURST),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_trans    (tx_trans),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame-level view (sending / remaining gap cycles / owner / burst).
    bit                m_busy, m_send, m_err;
    int                m_gap_left, m_owner, m_ptr, m_burst, m_wd;
    logic [DATA_W-1:0] m_data;
    logic [NREQ-1:0]   m_ack;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [DATA_W-1:0] byte_of(input int i);
        return req_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic start_new(input int w);
        m_owner = w;
        m_ptr   = w;
        m_data  = byte_of(w);
        m_send  = 1'b1;
        m_busy  = 1'b1;
        m_burst = 1;
        m_wd    = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_eval();
        int w;
        m_ack = '0;
        if (reset) begin
            m_busy = 0; m_send = 0; m_err = 0; m_gap_left = 0; m_owner = 0;
            m_ptr = NREQ - 1; m_burst = 0; m_wd = 0; m_data = '0;
        end else if (!m_busy) begin
            w = rr_pick(req, m_ptr);
            if (w >= 0) start_new(w);
        end else if (m_send) begin
            if (tx_done) begin
                m_send = 0;
                m_ack[m_owner] = 1'b1;
                m_gap_left = GAP_CYC;
            end
`ifdef UART_TX_SCHED_TIMEOUT_EN
            else begin
                m_wd++;
                if (m_wd == TIMEOUT) begin
                    m_send = 0;
                    m_err = 1;
                    m_gap_left = GAP_CYC;
                    m_burst = BURST;  // stalled owner gets no burst continuation
                end
            end
`endif
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                if (req[m_owner] && m_burst < BURST) begin
                    m_burst++;
                    m_data = byte_of(m_owner);
                    m_send = 1;
                    m_wd = 0;
                end else begin
                    w = rr_pick(req, m_ptr);
                    if (w >= 0) start_new(w);
                    else m_busy = 0;
                end
            end
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        check_eq("trans", tx_trans, m_send);
        check_eq("ack", ack, m_ack);
        check_eq("busy", busy, m_busy);
        if (m_busy) check_eq("grant_id", grant_id, m_owner);
        check_eq("tx_data", tx_data, m_data);
        check_eq("timeout_err", timeout_err, m_err);
    endtask

    task automatic set_byte(input int i, input logic [DATA_W-1:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    // Drop all requests and let the transmitter finish whatever is in flight.
    task automatic drain();
        int age = 0;
        req = '0;
        for (int k = 0; k < 64 && m_busy; k++) begin
            tx_done = m_send && (age >= 2);
            step();
            age = m_send ? age + 1 : 0;
        end
        tx_done = 1'b0;
        check_eq("drain_idle", busy, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int               nobs, next1, age, done_at, hi;
    bit               prev, r0_added;
    logic [1:0]       obs_id   [8];
    logic [7:0]       obs_data [8];
    logic [1:0]       exp_id   [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
    logic [7:0]       exp_data [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'h05};

    initial begin
        // Reset held three cycles with all requests high.
        reset = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_byte(i, 8'h10 + 8'(i));
        repeat (3) step();
        check_eq("rst_trans", tx_trans, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ack", ack, 4'b0);
        reset = 1'b0;
        step();
        check_eq("first_grant", grant_id, 2'd0);
        check_eq("first_trans", tx_trans, 1'b1);
        drain();

        // Single byte from requester 2.
        req = 4'b0100;
        set_byte(2, 8'hA5);
        step();
        check_eq("single_trans", tx_trans, 1'b1);
        check_eq("single_grant", grant_id, 2'd2);
        for (int k = 0; k < 9; k++) begin
            step();
            check_eq("single_hold", tx_data, 8'hA5);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        req = '0;
        check_eq("single_ack", ack, 4'b0100);
        check_eq("single_fall", tx_trans, 1'b0);
        step();
        check_eq("single_gap_busy", busy, 1'b1);
        step();
        check_eq("single_idle", busy, 1'b0);

        // Burst cap: owner 1 sends four bytes, yields to 0, then resumes.
        req = 4'b0010;
        set_byte(1, 8'h01);
        set_byte(0, 8'hAA);
        next1 = 2; nobs = 0; age = 0; prev = 0; r0_added = 0;
        for (int k = 0; k < 200 && nobs < 6; k++) begin
            tx_done = m_send && (age == 3);
            step();
            age = m_send ? age + 1 : 0;
            if (tx_trans && !prev) begin
                obs_id[nobs]   = grant_id;
                obs_data[nobs] = tx_data;
                nobs++;
            end
            prev = tx_trans;
            if (!r0_added) begin
                req[0] = 1'b1;
                r0_added = 1;
            end
            if (m_ack[1]) begin
                if (next1 <= 5) begin
                    set_byte(1, 8'(next1));
                    next1++;
                end else begin
                    req[1] = 1'b0;
                end
            end
            if (m_ack[0]) req[0] = 1'b0;
        end
        tx_done = 1'b0;
        check_eq("burst_frames", nobs, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < nobs) begin
                check_eq("burst_owner", obs_id[i], exp_id[i]);
                check_eq("burst_byte", obs_data[i], exp_data[i]);
            end
        end
        drain();

        // Reset in the middle of a frame: no ack, later tx_done ignored.
        req = 4'b1000;
        set_byte(3, 8'h5A);
        repeat (3) step();
        check_eq("midrst_sending", tx_trans, 1'b1);
        reset = 1'b1;
        req = '0;
        step();
        check_eq("midrst_trans", tx_trans, 1'b0);
        check_eq("midrst_ack", ack, 4'b0);
        reset = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_eq("midrst_noack", ack, 4'b0);
        check_eq("midrst_idle", busy, 1'b0);

        // Randomized traffic with variable frame lengths and stray tx_done pulses.
        age = 0; done_at = 1;
        for (int k = 0; k < 3000; k++) begin
            step();
            age = m_send ? age + 1 : 0;
            if (age == 1) done_at = $urandom_range(1, 10);
            for (int i = 0; i < NREQ; i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) set_byte(i, 8'($urandom));
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 5) == 0) begin
                    set_byte(i, 8'($urandom));
                    req[i] = 1'b1;
                end
            end
            tx_done = m_send ? (age == done_at) : ($urandom_range(0, 7) == 0);
        end
        tx_done = 1'b0;
        drain();

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Stalled transmitter: frame aborted after TIMEOUT cycles, next requester served.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b0100;
        set_byte(2, 8'h77);
        step();
        req = 4'b1100;
        set_byte(3, 8'h33);
        hi = 1;
        for (int k = 0; k < TIMEOUT + 8; k++) begin
            step();
            if (!tx_trans) break;
            hi++;
        end
        check_eq("to_len", hi, TIMEOUT);
        check_eq("to_err", timeout_err, 1'b1);
        check_eq("to_noack", ack, 4'b0);
        repeat (GAP_CYC) step();
        check_eq("to_next_trans", tx_trans, 1'b1);
        check_eq("to_next_grant", grant_id, 2'd3);
        drain();
        check_eq("to_sticky", timeout_err, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
